// File: rtl/cmos_pkg.sv
// Shared types and widths for the CMOS pixel packer.
package cmos_pkg;

  localparam int PIX_W   = 8;
  localparam int WORD_W  = 32;
  localparam int ENTRY_W = 34;
  localparam int LCNT_W  = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_DROP  = 2'd2
  } state_e;

  typedef struct packed {
    logic              sof;
    logic              eol;
    logic [WORD_W-1:0] data;
  } entry_t;

  // Place a pixel into its byte lane. Lane 0 starts a fresh word with the
  // upper lanes cleared, so a word cut short by a line end is already
  // zero-padded.
  function automatic logic [WORD_W-1:0] put_byte(
    input logic [WORD_W-1:0] w,
    input logic [1:0]        idx,
    input logic [PIX_W-1:0]  b
  );
    logic [WORD_W-1:0] r;
    r = w;
    case (idx)
      2'd0: r = {24'd0, b};
      2'd1: r[15:8]  = b;
      2'd2: r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO. Head entry is visible on rd_data
// whenever not empty; rd_data reads as zero while empty.
module sync_fifo_fwft #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             wr_ok, rd_ok;

  // Extra pointer bit distinguishes full from empty; a write into a full FIFO
  // is allowed when the head is leaving in the same cycle.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    rd_ok    = rd_en & ~empty;
    wr_ok    = wr_en & (~full | rd_ok);
    wr_ptr_d = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    rd_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/cmos_pixel_packer.sv
// Packs 8-bit CMOS pixels into 32-bit little-endian words with sof/eol
// markers, buffered in a FWFT FIFO with ready/valid output. An overflow
// truncates the rest of the frame and is counted.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | outside a frame, bytes ignored, waiting for vsync rise
// ST_FRAME | assembling and writing words for the current frame
// ST_DROP  | FIFO overflowed, discarding bytes until vsync falls
module cmos_pixel_packer
  import cmos_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int LINE_WORDS = 320
) (
  input  logic              cmos_pclk,
  input  logic              rst_n,
  input  logic              cmos_frame_vsync,
  input  logic              cmos_frame_href,
  input  logic [PIX_W-1:0]  cmos_frame_data,
  output logic [WORD_W-1:0] pkt_data,
  output logic              pkt_sof,
  output logic              pkt_eol,
  output logic              pkt_valid,
  input  logic              pkt_ready,
  output logic              frame_drop,
  output logic [15:0]       drop_cnt,
  output logic              line_err
);

  localparam logic [LCNT_W-1:0] LINE_WORDS_C = LCNT_W'(LINE_WORDS);

  state_e            state_q, state_d;
  logic              vs_d_q, hs_d_q;
  logic [1:0]        idx_q, idx_d;
  logic [WORD_W-1:0] asm_q, asm_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              word_rdy_q, word_rdy_d;
  logic              sof_pend_q, sof_pend_d;
  logic [LCNT_W-1:0] line_cnt_q, line_cnt_d;
  logic              line_err_q, line_err_d;
  logic              frame_drop_q, frame_drop_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;

  logic   frame_start, line_end, flush;
  logic   in_frame, enter_drop;
  logic   byte_in, part_wr, wr_req, overflow, wr_en, rd_en;
  logic   fifo_full, fifo_empty;
  entry_t wr_entry, rd_entry;

  // Edge detection and write request decode.
  always_comb begin
    frame_start = cmos_frame_vsync & ~vs_d_q;
    line_end    = ~cmos_frame_href & hs_d_q;
    // A line also ends when vsync drops in the middle of it.
    flush       = in_frame & (line_end | ~cmos_frame_vsync);
    part_wr     = flush & (idx_q != 2'd0);
    wr_req      = in_frame & (word_rdy_q | part_wr);
    rd_en       = pkt_valid & pkt_ready;
    overflow    = wr_req & fifo_full & ~rd_en;
    wr_en       = wr_req & ~overflow;
    byte_in     = in_frame & cmos_frame_vsync & cmos_frame_href & ~overflow;
    // The held full word and a partial word are never pending together: a
    // held word means the index already wrapped to zero.
    wr_entry.sof  = sof_pend_q;
    wr_entry.eol  = part_wr | (word_rdy_q & flush);
    wr_entry.data = word_rdy_q ? word_q : asm_q;
  end

  // FSM state register.
  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (frame_start) state_d = ST_FRAME;
      ST_FRAME: begin
        if (overflow)               state_d = ST_DROP;
        else if (!cmos_frame_vsync) state_d = ST_IDLE;
      end
      ST_DROP:  if (!cmos_frame_vsync) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    in_frame   = (state_q == ST_FRAME);
    enter_drop = in_frame & overflow;
  end

  // Datapath next-state: assembly, held word, markers, counters.
  always_comb begin
    idx_d        = idx_q;
    asm_d        = asm_q;
    word_d       = word_q;
    word_rdy_d   = 1'b0;
    sof_pend_d   = sof_pend_q;
    line_cnt_d   = line_cnt_q;
    line_err_d   = 1'b0;
    frame_drop_d = frame_drop_q;
    drop_cnt_d   = drop_cnt_q;

    if (!in_frame || flush || overflow) begin
      idx_d = 2'd0;
    end else if (byte_in) begin
      idx_d = idx_q + 2'd1;
    end

    if (byte_in) begin
      asm_d = put_byte(asm_q, idx_q, cmos_frame_data);
      if (idx_q == 2'd3) begin
        // Hold the completed word one cycle so eol can be decided from href.
        word_d     = asm_d;
        word_rdy_d = 1'b1;
      end
    end

    if (frame_start)  sof_pend_d = 1'b1;
    else if (wr_en)   sof_pend_d = 1'b0;

    if (!in_frame || flush) line_cnt_d = '0;
    else if (wr_req)        line_cnt_d = line_cnt_q + 1'b1;

    // Count includes the word written on the line-end cycle itself.
    if (in_frame && line_end && !overflow &&
        ((line_cnt_q + LCNT_W'(wr_req)) != LINE_WORDS_C))
      line_err_d = 1'b1;

    if (frame_start)     frame_drop_d = 1'b0;
    else if (enter_drop) frame_drop_d = 1'b1;

    if (enter_drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  // Datapath registers. vs_d resets high so a vsync already high at reset
  // release is not taken as a frame start; output resumes at the next rise.
  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d_q       <= 1'b1;
      hs_d_q       <= 1'b0;
      idx_q        <= 2'd0;
      asm_q        <= '0;
      word_q       <= '0;
      word_rdy_q   <= 1'b0;
      sof_pend_q   <= 1'b0;
      line_cnt_q   <= '0;
      line_err_q   <= 1'b0;
      frame_drop_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      vs_d_q       <= cmos_frame_vsync;
      hs_d_q       <= cmos_frame_href;
      idx_q        <= idx_d;
      asm_q        <= asm_d;
      word_q       <= word_d;
      word_rdy_q   <= word_rdy_d;
      sof_pend_q   <= sof_pend_d;
      line_cnt_q   <= line_cnt_d;
      line_err_q   <= line_err_d;
      frame_drop_q <= frame_drop_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  sync_fifo_fwft #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (cmos_pclk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_entry),
    .rd_en   (rd_en),
    .rd_data (rd_entry),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Output mapping.
  always_comb begin
    pkt_valid  = ~fifo_empty;
    pkt_data   = rd_entry.data;
    pkt_sof    = rd_entry.sof;
    pkt_eol    = rd_entry.eol;
    frame_drop = frame_drop_q;
    drop_cnt   = drop_cnt_q;
    line_err   = line_err_q;
  end

endmodule

// File: tb/tb_cmos_pixel_packer.sv
module tb_cmos_pixel_packer;
  import cmos_pkg::*;

  localparam int DEPTH = 16;
  localparam int LW    = 320;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vsync = 1'b0;
  logic        href = 1'b0;
  logic [7:0]  drv_data = 8'h00;
  logic        ready = 1'b1;
  logic [31:0] pkt_data;
  logic        pkt_sof, pkt_eol, pkt_valid;
  logic        frame_drop;
  logic [15:0] drop_cnt;
  logic        line_err;

  cmos_pixel_packer #(.FIFO_DEPTH(DEPTH), .LINE_WORDS(LW)) dut (
    .cmos_pclk        (clk),
    .rst_n            (rst_n),
    .cmos_frame_vsync (vsync),
    .cmos_frame_href  (href),
    .cmos_frame_data  (drv_data),
    .pkt_data         (pkt_data),
    .pkt_sof          (pkt_sof),
    .pkt_eol          (pkt_eol),
    .pkt_valid        (pkt_valid),
    .pkt_ready        (ready),
    .frame_drop       (frame_drop),
    .drop_cnt         (drop_cnt),
    .line_err         (line_err)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [33:0] exp_q[$];
  logic [7:0]  fbytes[$];
  int          flen[$];
  int          exp_lerr = 0;
  int          ready_mode = 0;
  int          err_seen = 0;
  int          n_xfer = 0;
  bit          mon_en = 1'b1;
  bit          valid_seen = 1'b0;
  bit          stall_q = 1'b0;
  logic [33:0] stall_word = '0;

  // Scoreboard: each accepted word is checked against the model queue, and
  // a stalled word must stay put until it is taken.
  always @(negedge clk) begin
    logic [33:0] obs, e;
    obs = {pkt_sof, pkt_eol, pkt_data};
    if (mon_en) begin
      if (stall_q) begin
        n_cmp++;
        if (pkt_valid !== 1'b1 || obs !== stall_word) begin
          n_err++;
          $display("FAIL stall_stable: got valid=%0b word=%09h, want valid=1 word=%09h",
                   pkt_valid, obs, stall_word);
        end
      end
      if (pkt_valid) valid_seen = 1'b1;
      if (pkt_valid && ready) begin
        n_xfer++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_word: got sof=%0b eol=%0b data=%08h, want none",
                   pkt_sof, pkt_eol, pkt_data);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            n_err++;
            $display("FAIL word: got sof=%0b eol=%0b data=%08h, want sof=%0b eol=%0b data=%08h",
                     obs[33], obs[32], obs[31:0], e[33], e[32], e[31:0]);
          end
        end
      end
      stall_q    = pkt_valid & ~ready;
      stall_word = obs;
    end else begin
      stall_q = 1'b0;
    end
    if (line_err === 1'b1) err_seen++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    case (ready_mode)
      0: ready = 1'b1;
      1: ready = 1'b0;
      2: ready = ~ready;
      default: ready = ($urandom_range(3) != 0);
    endcase
  endtask

  task automatic fill(input int nl, input int len, input bit seq, input logic [7:0] base);
    logic [7:0] v;
    v = base;
    fbytes.delete();
    flen.delete();
    for (int l = 0; l < nl; l++) begin
      int n;
      n = (len > 0) ? len : int'($urandom_range(13, 1));
      flen.push_back(n);
      for (int i = 0; i < n; i++) begin
        fbytes.push_back(seq ? v : 8'($urandom));
        v++;
      end
    end
  endtask

  // Reference: chop each line into groups of four pixels, little-endian,
  // zero-padded; eol on the last group of a line, sof on the first of a frame.
  task automatic model_frame();
    int p;
    bit first;
    p = 0;
    first = 1'b1;
    exp_lerr = 0;
    foreach (flen[l]) begin
      int n, nw;
      n  = flen[l];
      nw = (n + 3) / 4;
      if (nw != LW) exp_lerr++;
      for (int w = 0; w < nw; w++) begin
        logic [31:0] d;
        d = '0;
        for (int b = 0; b < 4; b++)
          if (w * 4 + b < n) d[8*b +: 8] = fbytes[p + w * 4 + b];
        exp_q.push_back({first, (w == nw - 1), d});
        first = 1'b0;
      end
      p += n;
    end
  endtask

  task automatic drive_frame();
    int p;
    p = 0;
    vsync = 1'b1;
    href  = 1'b0;
    repeat (3) tick();
    foreach (flen[l]) begin
      for (int i = 0; i < flen[l]; i++) begin
        href     = 1'b1;
        drv_data = fbytes[p + i];
        tick();
      end
      p += flen[l];
      href     = 1'b0;
      drv_data = 8'($urandom);
      repeat (2) tick();
    end
    tick();
    vsync = 1'b0;
    repeat (3) tick();
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 300 && pkt_valid; i++) tick();
    n_cmp++;
    if (pkt_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s_drain_timeout: got valid=%0b, want 0", name, pkt_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    n_cmp += 7;
    if (pkt_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %0b want 0", pkt_valid); end
    if (pkt_data !== 32'h0) begin n_err++; $display("FAIL rst_data: got %08h want 0", pkt_data); end
    if (pkt_sof !== 1'b0) begin n_err++; $display("FAIL rst_sof: got %0b want 0", pkt_sof); end
    if (pkt_eol !== 1'b0) begin n_err++; $display("FAIL rst_eol: got %0b want 0", pkt_eol); end
    if (frame_drop !== 1'b0) begin n_err++; $display("FAIL rst_drop: got %0b want 0", frame_drop); end
    if (drop_cnt !== 16'h0) begin n_err++; $display("FAIL rst_dropcnt: got %0d want 0", drop_cnt); end
    if (line_err !== 1'b0) begin n_err++; $display("FAIL rst_lineerr: got %0b want 0", line_err); end
    rst_n = 1'b1;
    repeat (2) tick();
    n_cmp++;
    if (pkt_valid !== 1'b0) begin n_err++; $display("FAIL post_rst_valid: got %0b want 0", pkt_valid); end
  endtask

  task automatic test_basic_frame();
    int e0;
    ready_mode = 0;
    fill(2, 8, 1'b1, 8'h00);
    model_frame();
    e0 = err_seen;
    drive_frame();
    wait_drain("basic");
    n_cmp += 2;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL basic_missing: got %0d left want 0", exp_q.size()); end
    if (err_seen - e0 != exp_lerr) begin
      n_err++; $display("FAIL basic_lineerr: got %0d want %0d", err_seen - e0, exp_lerr);
    end
  endtask

  task automatic test_short_line();
    int e0;
    ready_mode = 0;
    fill(1, 6, 1'b1, 8'hA1);
    model_frame();
    e0 = err_seen;
    drive_frame();
    wait_drain("short");
    n_cmp += 2;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL short_missing: got %0d left want 0", exp_q.size()); end
    if (err_seen - e0 != 1) begin n_err++; $display("FAIL short_lineerr: got %0d want 1", err_seen - e0); end
  endtask

  task automatic test_vsync_midline();
    ready_mode = 0;
    exp_q.push_back({1'b1, 1'b1, 32'h00CCBBAA});
    vsync = 1'b1;
    repeat (3) tick();
    href = 1'b1;
    drv_data = 8'hAA; tick();
    drv_data = 8'hBB; tick();
    drv_data = 8'hCC; tick();
    vsync = 1'b0;
    href  = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if (dut.state_q !== ST_IDLE) begin
      n_err++; $display("FAIL vsync_mid_state: got %0d want %0d", dut.state_q, ST_IDLE);
    end
    href = 1'b1;
    for (int i = 0; i < 8; i++) begin drv_data = 8'($urandom); tick(); end
    href = 1'b0;
    wait_drain("vsync_mid");
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL vsync_mid_missing: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_toggle_ready();
    ready_mode = 2;
    fill(2, 1280, 1'b0, 8'h00);
    model_frame();
    drive_frame();
    wait_drain("toggle");
    n_cmp += 3;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL toggle_missing: got %0d left want 0", exp_q.size()); end
    if (frame_drop !== 1'b0) begin n_err++; $display("FAIL toggle_drop: got %0b want 0", frame_drop); end
    if (drop_cnt !== 16'd0) begin n_err++; $display("FAIL toggle_dropcnt: got %0d want 0", drop_cnt); end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 5; f++) begin
      int e0;
      ready_mode = 3;
      fill(int'($urandom_range(3, 1)), 0, 1'b0, 8'h00);
      model_frame();
      e0 = err_seen;
      drive_frame();
      wait_drain("random");
      n_cmp += 2;
      if (exp_q.size() != 0) begin n_err++; $display("FAIL random_missing: frame %0d got %0d left want 0", f, exp_q.size()); end
      if (err_seen - e0 != exp_lerr) begin
        n_err++; $display("FAIL random_lineerr: frame %0d got %0d want %0d", f, err_seen - e0, exp_lerr);
      end
    end
  endtask

  task automatic test_overflow();
    int e0, x0;
    ready_mode = 1;
    fill(4, 1280, 1'b0, 8'h00);
    model_frame();
    while (exp_q.size() > DEPTH) void'(exp_q.pop_back());
    e0 = err_seen;
    x0 = n_xfer;
    drive_frame();
    n_cmp += 5;
    if (pkt_valid !== 1'b1) begin n_err++; $display("FAIL ovf_valid: got %0b want 1", pkt_valid); end
    if (frame_drop !== 1'b1) begin n_err++; $display("FAIL ovf_drop: got %0b want 1", frame_drop); end
    if (drop_cnt !== 16'd1) begin n_err++; $display("FAIL ovf_dropcnt: got %0d want 1", drop_cnt); end
    if (err_seen != e0) begin n_err++; $display("FAIL ovf_lineerr: got %0d want 0", err_seen - e0); end
    if (n_xfer != x0) begin n_err++; $display("FAIL ovf_early_xfer: got %0d want 0", n_xfer - x0); end
    ready_mode = 0;
    wait_drain("ovf");
    n_cmp += 2;
    if (n_xfer - x0 != DEPTH) begin n_err++; $display("FAIL ovf_count: got %0d want %0d", n_xfer - x0, DEPTH); end
    if (exp_q.size() != 0) begin n_err++; $display("FAIL ovf_missing: got %0d left want 0", exp_q.size()); end
    fill(1, 4, 1'b1, 8'h40);
    model_frame();
    vsync = 1'b1;
    repeat (2) tick();
    n_cmp++;
    if (frame_drop !== 1'b0) begin n_err++; $display("FAIL next_frame_drop: got %0b want 0", frame_drop); end
    drive_frame();
    wait_drain("next_frame");
    n_cmp += 2;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL next_frame_missing: got %0d left want 0", exp_q.size()); end
    if (drop_cnt !== 16'd1) begin n_err++; $display("FAIL next_frame_dropcnt: got %0d want 1", drop_cnt); end
  endtask

  task automatic test_reset_midframe();
    ready_mode = 1;
    tick();
    vsync = 1'b1;
    repeat (3) tick();
    href = 1'b1;
    for (int i = 0; i < 21; i++) begin drv_data = 8'($urandom); tick(); end
    n_cmp++;
    if (pkt_valid !== 1'b1) begin n_err++; $display("FAIL midrst_queued: got %0b want 1", pkt_valid); end
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    n_cmp += 2;
    if (pkt_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %0b want 0", pkt_valid); end
    if (pkt_data !== 32'h0) begin n_err++; $display("FAIL midrst_data: got %08h want 0", pkt_data); end
    repeat (2) tick();
    n_cmp += 2;
    if (drop_cnt !== 16'd0) begin n_err++; $display("FAIL midrst_dropcnt: got %0d want 0", drop_cnt); end
    if (frame_drop !== 1'b0) begin n_err++; $display("FAIL midrst_drop: got %0b want 0", frame_drop); end
    rst_n      = 1'b1;
    ready_mode = 0;
    valid_seen = 1'b0;
    mon_en     = 1'b1;
    for (int i = 0; i < 12; i++) begin drv_data = 8'($urandom); tick(); end
    href = 1'b0;
    repeat (4) tick();
    href = 1'b1;
    for (int i = 0; i < 8; i++) begin drv_data = 8'($urandom); tick(); end
    href = 1'b0;
    repeat (3) tick();
    vsync = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (valid_seen !== 1'b0) begin n_err++; $display("FAIL midrst_output: got valid seen=%0b want 0", valid_seen); end
    fill(2, 5, 1'b0, 8'h00);
    model_frame();
    drive_frame();
    wait_drain("midrst_resume");
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL midrst_resume_missing: got %0d left want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_short_line();
    test_vsync_midline();
    test_toggle_ready();
    test_random_frames();
    test_overflow();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cmos_pixel_packer.md
CMOS_PIXEL_PACKER -- requirements
Module: cmos_pixel_packer

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, output FIFO depth in 34-bit entries; power of two, 4..256.
REQ-002 Parameter LINE_WORDS, default 320, expected 32-bit words per line (1280 px / 4); used only for line_err.
REQ-003 cmos_pclk  in  1  sole clock, pixel clock domain; no other clock is present.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 cmos_frame_vsync  in  1  frame valid, high for the whole frame.
REQ-006 cmos_frame_href  in  1  pixel valid, high for each active line.
REQ-007 cmos_frame_data  in  8  gray/RAW pixel, valid when href=1.
REQ-008 pkt_data  out  32  packed word; first pixel of the group in bits [7:0], little-endian.
REQ-009 pkt_sof  out  1  marks the first word of a frame.
REQ-010 pkt_eol  out  1  marks the last word of a line.
REQ-011 pkt_valid  out  1  word available.
REQ-012 pkt_ready  in  1  consumer accepts the word.
REQ-013 frame_drop  out  1  sticky until next frame start: current frame truncated by overflow.
REQ-014 drop_cnt  out  16  dropped frames, saturating at 16'hFFFF.
REQ-015 line_err  out  1  one-cycle pulse when a line's word count differs from LINE_WORDS.

Function
REQ-016 The block SHALL register vsync and href once (vs_d, hs_d) and detect frame start as vsync & ~vs_d and line end as ~href & hs_d.
REQ-017 FSM states SHALL be IDLE, FRAME, DROP; reset enters IDLE.
REQ-018 IDLE->FRAME on frame start; FRAME->IDLE on vsync low; FRAME->DROP on a write attempted while the FIFO is full; DROP->IDLE on vsync low.
REQ-019 In FRAME, each byte with href=1 SHALL shift into a 2-bit-indexed assembly register, and the 4th byte SHALL produce a FIFO write on the next cycle (latency 1 clock after byte 4).
REQ-020 On line end with 1..3 bytes pending, the partial word SHALL be written zero-padded in the upper bytes; with 0 bytes pending, the previous word written for that line SHALL carry eol instead.
REQ-021 eol handling: the final word of a line is held one cycle before the write so that eol is attached to it; no empty word SHALL ever be written.
REQ-022 The first word written after frame start SHALL carry sof=1; every other word SHALL carry sof=0.
REQ-023 A FIFO entry SHALL be {sof, eol, data}; the output SHALL be first-word-fall-through, with pkt_valid = ~empty.
REQ-024 A transfer SHALL occur when pkt_valid & pkt_ready; pkt_data, pkt_sof and pkt_eol SHALL hold stable while valid & ~ready.
REQ-025 A simultaneous read and write on a full FIFO SHALL succeed; the write SHALL not count as overflow.
REQ-026 On entering DROP, the block SHALL set frame_drop and increment drop_cnt; all further bytes of that frame SHALL be discarded; words already queued SHALL still drain.
REQ-027 frame_drop SHALL clear on the next frame start.
REQ-028 Bytes outside FRAME SHALL be ignored, and the assembly index SHALL reset to 0 at every line end and at vsync low.
REQ-029 If vsync falls mid-line, pending bytes SHALL be flushed as in REQ-020 with eol=1.
REQ-030 The per-line word counter SHALL be 10 bits wide and SHALL be compared at line end; line_err SHALL not fire in DROP.

Reset
REQ-031 Reset SHALL set state IDLE, FIFO empty, pkt_valid=0, pkt_data=0, pkt_sof=0, pkt_eol=0, frame_drop=0, drop_cnt=0, line_err=0, assembly index 0, line counter 0.
REQ-032 Reset asserted mid-frame SHALL discard FIFO contents; after release, output SHALL resume only from the next frame start.

Structure
REQ-033 Package cmos_pkg SHALL hold the state enum, the FIFO entry width (34) and the pixel width (8).
REQ-034 The FIFO SHALL be one sub-module, sync_fifo_fwft (parameters DEPTH, WIDTH; outputs full/empty), and everything else SHALL stay in cmos_pixel_packer.

Verification
REQ-035 One frame of 2 lines x 8 px, bytes 0x00..0x0F, ready=1 -> words 0x03020100(sof), 0x07060504(eol), 0x0B0A0908, 0x0F0E0D0C(eol).
REQ-036 Line of 6 px (0xA1..0xA6) -> 0xA4A3A2A1, then 0x0000A6A5 with eol=1; line_err=1 with LINE_WORDS=320.
REQ-037 ready=0 for a full 1280x4 frame with FIFO_DEPTH=16 -> 16 words held, frame_drop=1, drop_cnt=1; after ready=1, exactly 16 words drain; the next frame has sof and frame_drop=0.
REQ-038 ready toggling 1/0 every cycle, 1280x2 frame -> all 640 words in order, no drop, data stable while stalled.
REQ-039 vsync falls after 3 bytes of a line -> one word 0x00CCBBAA with eol=1, state IDLE.
REQ-040 rst_n low for 2 cycles mid-line with 5 words queued -> pkt_valid=0 at once, drop_cnt=0; no output until the next vsync rise.
